alu_sequencer: RTL and testbench

Multi-cycle issue/capture controller wrapped around the combinational ALU in the datapath. Accepts an operation and two operands on a start handshake, drives the ALU opcode/exec/operand inputs for a parameterised number of settle cycles (longer for MUL/DIV), then captures the 64-bit result into the Z pair (z_hi:z_lo), and for MUL/DIV also into the architectural HI/LO registers. Pulses done when capture is complete. Flags divide-by-zero and illegal opcodes without touching result registers.

---
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/capture sequencer for the multi-cycle combinational ALU: latches a request,
// holds the ALU inputs for a settle window, then captures the 64-bit result.
module alu_sequencer #(
  parameter int FAST_WAIT   = 1,
  parameter int MULDIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        illegal_op,
  output logic [3:0]  alu_opcode,
  output logic        alu_exec,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic [31:0] lo_reg,
  output logic [31:0] hi_reg
);

  localparam logic [3:0] OP_MUL      = 4'd11;
  localparam logic [3:0] OP_DIV      = 4'd12;
  localparam logic [3:0] FAST_LOAD   = 4'(FAST_WAIT - 1);
  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_WAIT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       req_illegal, req_dbz, req_muldiv, cap_muldiv;

  assign req_illegal = (op >= 4'd13);
  assign req_dbz     = (op == OP_DIV) && (b_in == '0);
  assign req_muldiv  = (op == OP_MUL) || (op == OP_DIV);
  assign cap_muldiv  = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_exec  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (req_illegal || req_dbz) ? DONE : EXEC;
      EXEC: begin
        busy     = 1'b1;
        alu_exec = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rejected requests only raise a flag; operand and result registers stay untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      z_lo        <= '0;
      z_hi        <= '0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
          if (start) begin
            if (req_illegal)  illegal_op  <= 1'b1;
            else if (req_dbz) div_by_zero <= 1'b1;
            else begin
              alu_opcode <= op;
              alu_a      <= a_in;
              alu_b      <= b_in;
              cnt        <= req_muldiv ? MULDIV_LOAD : FAST_LOAD;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          else begin
            z_lo <= alu_result;
            z_hi <= alu_hi;
            if (cap_muldiv) begin
              lo_reg <= alu_result;
              hi_reg <= alu_hi;
            end
          end
        end
        DONE: begin
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; a behavioural ALU closes the loop on the datapath.
module tb_alu_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        busy, done, div_by_zero, illegal_op, alu_exec;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result, alu_hi, z_lo, z_hi, lo_reg, hi_reg;
  logic [63:0] prod;

  int checks = 0, errors = 0;

  alu_sequencer #(.FAST_WAIT(1), .MULDIV_WAIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
    .alu_opcode(alu_opcode), .alu_exec(alu_exec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_hi(alu_hi), .z_lo(z_lo), .z_hi(z_hi),
    .lo_reg(lo_reg), .hi_reg(hi_reg)
  );

  always #5 clk = ~clk;

  always_comb begin
    prod       = 64'(alu_a) * 64'(alu_b);
    alu_result = '0;
    alu_hi     = '0;
    case (alu_opcode)
      4'd0:  alu_result = alu_a + alu_b;
      4'd11: {alu_hi, alu_result} = prod;
      4'd12: if (alu_b != '0) begin
        alu_result = alu_a / alu_b;
        alu_hi     = alu_a % alu_b;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, div_by_zero, illegal_op, alu_exec, alu_opcode}), 64'd0);
    chk({tag, "_ab"},  {alu_a, alu_b}, 64'd0);
    chk({tag, "_z"},   {z_hi, z_lo}, 64'd0);
    chk({tag, "_hl"},  {hi_reg, lo_reg}, 64'd0);
  endtask

  // Issues one request at cycle 0 and observes until done (bounded); returns in IDLE.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nexec, output int nbusy,
                        output logic dbz, output logic ill);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; nexec = 0; nbusy = 0; dbz = 1'b0; ill = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      nexec += int'(alu_exec);
      nbusy += int'(busy);
      if (done) begin
        lat = c; dbz = div_by_zero; ill = illegal_op;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("timeout", 64'd0, 64'd1);
  endtask

  int lat, nexec, nbusy, ndone, d1, d2;
  logic dbz, ill;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // ADD 5+7
    @(posedge clk); #1;
    run_op(4'd0, 32'd5, 32'd7, lat, nexec, nbusy, dbz, ill);
    chk("add_lat", 64'(lat), 64'd2);
    chk("add_exec", 64'(nexec), 64'd1);
    chk("add_z", {z_hi, z_lo}, 64'd12);
    chk("add_hl", {hi_reg, lo_reg}, 64'd0);

    // MUL 0x10000 * 0x10000
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, lat, nexec, nbusy, dbz, ill);
    chk("mul_lat", 64'(lat), 64'd5);
    chk("mul_busy", 64'(nbusy), 64'd4);
    chk("mul_z", {z_hi, z_lo}, 64'h1_0000_0000);
    chk("mul_hl", {hi_reg, lo_reg}, 64'h1_0000_0000);

    // DIV 17/5
    run_op(4'd12, 32'd17, 32'd5, lat, nexec, nbusy, dbz, ill);
    chk("div_lat", 64'(lat), 64'd5);
    chk("div_hl", {hi_reg, lo_reg}, {32'd2, 32'd3});
    chk("div_z", {z_hi, z_lo}, {32'd2, 32'd3});

    // DIV 9/0
    run_op(4'd12, 32'd9, 32'd0, lat, nexec, nbusy, dbz, ill);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_flag", 64'({dbz, ill}), 64'b10);
    chk("dbz_exec", 64'(nexec), 64'd0);
    chk("dbz_hl", {hi_reg, lo_reg}, {32'd2, 32'd3});
    chk("dbz_nolatch", {alu_a, alu_b}, {32'd17, 32'd5});
    @(negedge clk);
    chk("dbz_clear", 64'({div_by_zero, illegal_op}), 64'd0);
    @(posedge clk); #1;

    // illegal opcode
    run_op(4'hE, 32'd1, 32'd2, lat, nexec, nbusy, dbz, ill);
    chk("ill_lat", 64'(lat), 64'd1);
    chk("ill_flag", 64'({dbz, ill}), 64'b01);
    chk("ill_busy", 64'(nbusy), 64'd0);
    chk("ill_zlo", 64'(z_lo), 64'd3);

    // MUL 3*4 with start held during EXEC/DONE; ADD accepted in the next IDLE cycle
    start = 1'b1; op = 4'd11; a_in = 32'd3; b_in = 32'd4;
    ndone = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin op = 4'd0; a_in = 32'd100; b_in = 32'd200; end
      if (c == 7) start = 1'b0;
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c; else d2 = c;
        if (c == 5) chk("ign_mul_lo", 64'(lo_reg), 64'd12);
      end
    end
    chk("ign_ndone", 64'(ndone), 64'd2);
    chk("ign_d1", 64'(d1), 64'd5);
    chk("ign_d2", 64'(d2), 64'd8);
    chk("ign_add_z", {z_hi, z_lo}, 64'd300);
    chk("ign_hl", {hi_reg, lo_reg}, 64'd12);

    // reset in second EXEC cycle of a MUL
    @(posedge clk); #1;
    start = 1'b1; op = 4'd11; a_in = 32'h0001_0000; b_in = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("midrst_nodone", 64'(ndone), 64'd0);
    @(posedge clk); #1;
    run_op(4'd0, 32'd1, 32'd1, lat, nexec, nbusy, dbz, ill);
    chk("post_lat", 64'(lat), 64'd2);
    chk("post_z", {z_hi, z_lo}, 64'd2);
    chk("post_hl", {hi_reg, lo_reg}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
